// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, FSM states and sizing helper for the HI/LO multiply/divide unit
package mdu_pkg;

  localparam logic [2:0] MDU_MULTU = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;
  localparam logic [2:0] MDU_MTHI  = 3'b100;
  localparam logic [2:0] MDU_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// rtl/mdu_div_step.sv - one restoring-division step (one quotient bit)
// Ports:
//   rem      in   WIDTH  current partial remainder
//   next_bit in   1      next dividend bit shifted into the remainder
//   divisor  in   WIDTH  divisor magnitude
//   rem_next out  WIDTH  partial remainder after this step
//   q_bit    out  1      quotient bit produced by this step
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] diff;

  always_comb begin
    partial  = {rem, next_bit};
    // Extra top bit acts as the borrow: set means partial < divisor.
    diff     = {1'b0, partial} - {2'b00, divisor};
    q_bit    = ~diff[WIDTH+1];
    rem_next = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative multiply/divide unit with architectural HI/LO registers
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start, op    issue request and operation (MULTU/MULT/DIVU/DIV/MTHI/MTLO)
//   a, b         operands (a also carries MTHI/MTLO data)
//   abort        cancel an in-flight multiply/divide
//   busy, done   multiply/divide in progress; one-cycle result pulse
//   div_by_zero  sticky flag for the last accepted multiply/divide
//   hi, lo       HI/LO registers
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = clog2(WIDTH);

  mdu_state_e state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic             div_q;      // running op is a divide
  logic             neg_q;      // negate product / quotient at FIX
  logic             rem_neg_q;  // remainder takes the dividend's sign
  logic [WIDTH-1:0] a_q;        // raw dividend, returned in HI on divide by zero
  logic [WIDTH-1:0] opb_q;      // multiplicand (mult) or divisor (div) magnitude
  logic [WIDTH-1:0] acc_hi_q;
  logic [WIDTH-1:0] acc_lo_q;

  logic             accept;
  logic             mt_write;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;
  logic [WIDTH-1:0] div_rem_next;
  logic             div_q_bit;
  logic [WIDTH-1:0] div_lo_next;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign busy     = (state_q != IDLE);
  assign accept   = (state_q == IDLE) && start && !abort && !op[2];
  assign mt_write = (state_q == IDLE) && start && !abort &&
                    ((op == MDU_MTHI) || (op == MDU_MTLO));

  // Signed ops work on magnitudes; op[0] marks the signed variants.
  assign a_abs = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_abs = (op[0] && b[WIDTH-1]) ? -b : b;

  // Shift-add: LO holds the remaining multiplier bits, product shifts in from the top.
  always_comb begin
    mul_sum     = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
  end

  // Restoring divide: LO shifts dividend bits out the top and quotient bits in the bottom.
  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc_hi_q),
    .next_bit (acc_lo_q[WIDTH-1]),
    .divisor  (opb_q),
    .rem_next (div_rem_next),
    .q_bit    (div_q_bit)
  );

  assign div_lo_next = {acc_lo_q[WIDTH-2:0], div_q_bit};

  always_comb begin
    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_q ? -prod : prod;
    quot_fix = neg_q ? -acc_lo_q : acc_lo_q;
    rem_fix  = rem_neg_q ? -acc_hi_q : acc_hi_q;
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
    if (div_q) begin
      if (div_by_zero) begin
        res_hi = a_q;
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_hi = rem_fix;
        res_lo = quot_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = CALC;
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = FIX;
        end
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      div_q       <= 1'b0;
      neg_q       <= 1'b0;
      rem_neg_q   <= 1'b0;
      a_q         <= '0;
      opb_q       <= '0;
      acc_hi_q    <= '0;
      acc_lo_q    <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_q       <= CW'(WIDTH - 1);
            div_q       <= op[1];
            neg_q       <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_q   <= op[0] & a[WIDTH-1];
            div_by_zero <= op[1] & (b == '0);
            a_q         <= a;
            acc_hi_q    <= '0;
            if (op[1]) begin
              acc_lo_q <= a_abs;
              opb_q    <= b_abs;
            end else begin
              acc_lo_q <= b_abs;
              opb_q    <= a_abs;
            end
          end else if (mt_write) begin
            if (op == MDU_MTHI) begin
              hi <= a;
            end else begin
              lo <= a;
            end
          end
        end
        CALC: begin
          if (!abort) begin
            cnt_q <= cnt_q - CW'(1);
            if (div_q) begin
              acc_hi_q <= div_rem_next;
              acc_lo_q <= div_lo_next;
            end else begin
              acc_hi_q <= mul_hi_next;
              acc_lo_q <= mul_lo_next;
            end
          end
        end
        FIX: begin
          if (!abort) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - self-checking bench for mdu_hilo against an arithmetic reference model
module tb_mdu_hilo;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         abort = 1'b0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  mdu_hilo #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Architectural result {HI, LO} of a multiply/divide, from plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint      sx, sy, q, m;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    case (o)
      3'b000: r = {32'd0, x} * {32'd0, y};
      3'b001: r = sx * sy;
      3'b010: r = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      3'b011: begin
        if (y == 0) begin
          r = {x, 32'hFFFFFFFF};
        end else begin
          q = sx / sy;
          m = sx % sy;
          r = {m[31:0], q[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Model: cycles of busy remaining, pending result, and visible state.
  int          m_left = 0;
  logic        m_done = 1'b0;
  logic        m_dbz = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (abort) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= m_res[63:32];
            m_lo   <= m_res[31:0];
            m_done <= 1'b1;
          end
        end
      end else if (start && !abort) begin
        if (op <= 3'd3) begin
          m_res  <= ref_result(op, a, b);
          m_dbz  <= op[1] && (b == 0);
          m_left <= W + 1;
        end else if (op == 3'd4) begin
          m_hi <= a;
        end else if (op == 3'd5) begin
          m_lo <= a;
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (busy !== (m_left > 0) || done !== m_done || div_by_zero !== m_dbz ||
        hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL cycle_compare t=%0t busy=%b/%b done=%b/%b dbz=%b/%b hi=%h/%h lo=%h/%h",
               $time, busy, (m_left > 0), done, m_done, div_by_zero, m_dbz,
               hi, m_hi, lo, m_lo);
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(posedge clk);
    #1;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Called just after the accept edge; returns edges to done and busy cycles seen.
  task automatic wait_done(input string nm, output int lat, output int busy_cycles);
    lat         = 0;
    busy_cycles = busy ? 1 : 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
      if (done) return;
      if (busy) busy_cycles++;
    end
    errors++;
    $display("FAIL %s timeout waiting for done", nm);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h80000000;
      3:       return W'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int           lat;
    int           bc;
    logic         seen;
    logic [2:0]   o;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           k;

    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_flags", {busy, done, div_by_zero}, 0);
    rst_n = 1'b1;

    check("model_divu", ref_result(3'b010, 32'd7, 32'd2), 64'h00000001_00000003);
    check("model_mult", ref_result(3'b001, 32'hFFFFFFFD, 32'd5), 64'hFFFFFFFF_FFFFFFF1);
    check("model_div_min", ref_result(3'b011, 32'h80000000, 32'hFFFFFFFF),
          64'h00000000_80000000);

    issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", lat, bc);
    check("multu_latency", lat, 33);
    check("multu_busy_cycles", bc, 33);
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    issue(3'b001, 32'hFFFFFFFD, 32'd5);
    wait_done("mult_neg", lat, bc);
    check("mult_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

    issue(3'b011, 32'hFFFFFFF9, 32'd2);
    wait_done("div_neg", lat, bc);
    check("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    issue(3'b010, 32'd7, 32'd2);
    wait_done("divu_7_2", lat, bc);
    check("divu_7_2_hilo", {hi, lo}, 64'h00000001_00000003);

    issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
    wait_done("div_min", lat, bc);
    check("div_min_hilo", {hi, lo}, 64'h00000000_80000000);

    issue(3'b010, 32'd5, 32'd0);
    wait_done("divu_zero", lat, bc);
    check("divu_zero_latency", lat, 33);
    check("divu_zero_hilo", {hi, lo}, 64'h00000005_FFFFFFFF);
    check("divu_zero_flag", div_by_zero, 1);

    issue(3'b100, 32'h1234, 32'd0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_flag_kept", {busy, div_by_zero}, 2'b01);

    // Start while busy is ignored; abort cancels without touching HI/LO.
    issue(3'b000, 32'd9, 32'd9);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;
    op    = 3'b010;
    a     = 32'd100;
    b     = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy_low", busy, 0);
    check("abort_hilo_kept", {hi, lo}, 64'h00001234_FFFFFFFF);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= done | busy;
    end
    check("abort_no_done", seen, 0);

    // Start and abort together in IDLE: not accepted.
    @(posedge clk);
    #1;
    start = 1'b1;
    abort = 1'b1;
    op    = 3'b000;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", busy, 0);

    issue(3'b110, 32'h5555, 32'h3);
    check("reserved_op_ignored", {busy, hi, lo}, {1'b0, 64'h00001234_FFFFFFFF});

    // Asynchronous reset in the middle of a multiply.
    issue(3'b001, 32'd123, 32'd456);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_hilo", {hi, lo}, 0);
    check("async_reset_flags", {busy, done, div_by_zero}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(3'b000, 32'd6, 32'd7);
    wait_done("multu_6_7", lat, bc);
    check("multu_6_7_hilo", {hi, lo}, 64'd42);

    // Randomised traffic with stray starts and occasional aborts.
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick();
      y = pick();
      issue(o, x, y);
      if (busy) begin
        k = $urandom_range(0, 60);
        for (int c = 0; c < 45 && busy; c++) begin
          start = ($urandom_range(0, 3) == 0);
          op    = 3'($urandom_range(0, 7));
          a     = $urandom;
          b     = $urandom;
          abort = (c == k);
          @(posedge clk);
          #1;
        end
        start = 1'b0;
        abort = 1'b0;
        check("random_op_settled", busy, 0);
      end
    end

    repeat (2) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
